// File: rtl/cond_unit.sv
// Condition-execution stage: holds architectural NZCV flags, evaluates the ARM
// condition field once per instruction and qualifies the control FSM write strobes.
module cond_unit #(
    parameter int unsigned NFLAGS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [NFLAGS-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              CondLatch,
    input  logic              PCS,
    input  logic              NextPC,
    input  logic              RegW,
    input  logic              MemW,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [NFLAGS-1:0] Flags,
    output logic              CarryIn,
    output logic              CondExR
);

    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    logic [NFLAGS-1:0] flags_q;
    logic              cond_ex_q;
    logic              cond_ex;
    logic [1:0]        flag_write;
    logic              n_flag;
    logic              z_flag;
    logic              c_flag;
    logic              v_flag;

    assign n_flag = flags_q[N_BIT];
    assign z_flag = flags_q[Z_BIT];
    assign c_flag = flags_q[C_BIT];
    assign v_flag = flags_q[V_BIT];

    // Condition decode against the current architectural flags; 1111 never passes.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag writes are gated by the condition captured for the current instruction.
    assign flag_write = FlagW & {2{cond_ex_q}};

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            if (CondLatch) begin
                cond_ex_q <= cond_ex;
            end
            if (flag_write[1]) begin
                flags_q[N_BIT:Z_BIT] <= ALUFlags[N_BIT:Z_BIT];
            end
            if (flag_write[0]) begin
                flags_q[C_BIT:V_BIT] <= ALUFlags[C_BIT:V_BIT];
            end
        end
    end

    // Fetch increment is never suppressed; everything else waits on the latched condition.
    assign PCWrite  = NextPC | (PCS & cond_ex_q);
    assign RegWrite = RegW & cond_ex_q;
    assign MemWrite = MemW & cond_ex_q;
    assign Flags    = flags_q;
    assign CarryIn  = flags_q[C_BIT];
    assign CondExR  = cond_ex_q;

endmodule
